// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: free-running pixel/line counters decoded into sync, blanking and strobes.
// Latency: every output is a register that lines up with the hcount/vcount presented in the same cycle.
// Backpressure: pix_en=0 freezes counters, phases and levels; the line_start/frame_start strobes drop to 0.
//
// Ports:
//   clk_in      pixel clock; all state changes on its rising edge
//   reset       synchronous, active-high; loads the "last blanking pixel" state (799,524)
//   pix_en      pixel advance enable
//   hcount      current column 0..H_TOTAL-1
//   vcount      current line 0..V_TOTAL-1
//   hsync_n     active-low horizontal sync
//   vsync_n     active-low vertical sync
//   video_on    visible region
//   line_start  one-cycle strobe at hcount==0
//   frame_start one-cycle strobe at (0,0)
//   rgb         (only when VGA_TEST_PATTERN_EN is defined) 4:4:4 colour-bar pattern
//
// Optional feature macro: VGA_TEST_PATTERN_EN adds the rgb test-pattern output.

module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       video_on,
    output logic       line_start,
`ifdef VGA_TEST_PATTERN_EN
    output logic [11:0] rgb,
`endif
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide; larger timings cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_phase
        $error("vga_sync_gen: every phase must be at least one unit long");
    end

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FP_START  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SY_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_FP_START  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SY_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START  = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {H_ACTIVE_ST, H_FP_ST, H_SYNC_ST, H_BP_ST} h_state_e;
    typedef enum logic [1:0] {V_ACTIVE_ST, V_FP_ST, V_SYNC_ST, V_BP_ST} v_state_e;

    h_state_e   h_state_q, h_state_d;
    v_state_e   v_state_q, v_state_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;
    logic       video_on_q, video_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       h_wrap;

    assign h_wrap = pix_en && (hcount_q == H_LAST);

    // Next counts. Every registered output is decoded from these so it lands
    // in the same cycle as the count it describes.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (h_wrap) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Horizontal phase: moves only when the next count crosses a boundary.
    always_comb begin
        h_state_d = h_state_q;
        if (pix_en) begin
            case (h_state_q)
                H_ACTIVE_ST: if (hcount_d == H_FP_START) h_state_d = H_FP_ST;
                H_FP_ST:     if (hcount_d == H_SY_START) h_state_d = H_SYNC_ST;
                H_SYNC_ST:   if (hcount_d == H_BP_START) h_state_d = H_BP_ST;
                H_BP_ST:     if (hcount_d == 10'd0)      h_state_d = H_ACTIVE_ST;
                default:     h_state_d = H_BP_ST;
            endcase
        end
    end

    // Vertical phase: only ever evaluated on the horizontal wrap.
    always_comb begin
        v_state_d = v_state_q;
        if (h_wrap) begin
            case (v_state_q)
                V_ACTIVE_ST: if (vcount_d == V_FP_START) v_state_d = V_FP_ST;
                V_FP_ST:     if (vcount_d == V_SY_START) v_state_d = V_SYNC_ST;
                V_SYNC_ST:   if (vcount_d == V_BP_START) v_state_d = V_BP_ST;
                V_BP_ST:     if (vcount_d == 10'd0)      v_state_d = V_ACTIVE_ST;
                default:     v_state_d = V_BP_ST;
            endcase
        end
    end

    always_comb begin
        hsync_n_d     = (h_state_d != H_SYNC_ST);
        vsync_n_d     = (v_state_d != V_SYNC_ST);
        video_on_d    = (h_state_d == H_ACTIVE_ST) && (v_state_d == V_ACTIVE_ST);
        // Strobes qualified with pix_en so a stall never stretches them.
        line_start_d  = pix_en && (hcount_d == 10'd0);
        frame_start_d = pix_en && (hcount_d == 10'd0) && (vcount_d == 10'd0);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            h_state_q     <= H_BP_ST;
            v_state_q     <= V_BP_ST;
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal-width bars across the visible line (80 px at 640).
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb;
    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hcount_d >= 10'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = 12'hFFF; // white
            3'd1:    bar_rgb = 12'hFF0; // yellow
            3'd2:    bar_rgb = 12'h0FF; // cyan
            3'd3:    bar_rgb = 12'h0F0; // green
            3'd4:    bar_rgb = 12'hF0F; // magenta
            3'd5:    bar_rgb = 12'hF00; // red
            3'd6:    bar_rgb = 12'h00F; // blue
            default: bar_rgb = 12'h000; // black
        endcase
        rgb_d = video_on_d ? bar_rgb : 12'h000;
    end

    always_ff @(posedge clk_in) begin
        if (reset) rgb_q <= 12'h000;
        else       rgb_q <= rgb_d;
    end

    assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    logic       clk_in;
    logic       reset, pix_en;
    logic [9:0] hcount, vcount;
    logic       hsync_n, vsync_n, video_on, line_start, frame_start;

    logic       s_reset, s_pix_en;
    logic [9:0] s_hcount, s_vcount;
    logic       s_hsync_n, s_vsync_n, s_video_on, s_line_start, s_frame_start;

`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] rgb, s_rgb;
`endif

    int checks = 0;
    int errors = 0;

    vga_sync_gen dut (
        .clk_in(clk_in), .reset(reset), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .video_on(video_on),
        .line_start(line_start),
`ifdef VGA_TEST_PATTERN_EN
        .rgb(rgb),
`endif
        .frame_start(frame_start)
    );

    // Tiny timing (16 px x 8 lines) so whole frames fit in a short run.
    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk_in(clk_in), .reset(s_reset), .pix_en(s_pix_en),
        .hcount(s_hcount), .vcount(s_vcount),
        .hsync_n(s_hsync_n), .vsync_n(s_vsync_n), .video_on(s_video_on),
        .line_start(s_line_start),
`ifdef VGA_TEST_PATTERN_EN
        .rgb(s_rgb),
`endif
        .frame_start(s_frame_start)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    typedef struct {
        int   n;      // cycles to apply these inputs
        logic rst;
        logic pen;
        int   h, v;
        logic hs, vs, von, ls, fs;
    } vec_t;

    vec_t tv[10];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int h, input int v,
                           input logic hs, input logic vs, input logic von,
                           input logic ls, input logic fs);
        chk({tag, "_hcount"}, int'(hcount), h);
        chk({tag, "_vcount"}, int'(vcount), v);
        chk({tag, "_hsync_n"}, int'(hsync_n), int'(hs));
        chk({tag, "_vsync_n"}, int'(vsync_n), int'(vs));
        chk({tag, "_video_on"}, int'(video_on), int'(von));
        chk({tag, "_line_start"}, int'(line_start), int'(ls));
        chk({tag, "_frame_start"}, int'(frame_start), int'(fs));
`ifdef VGA_TEST_PATTERN_EN
        chk({tag, "_rgb"}, int'(rgb), exp_rgb(h, von));
`endif
    endtask

    function automatic int exp_rgb(input int h, input logic von);
        int colors[8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                          12'hF0F, 12'hF00, 12'h00F, 12'h000};
        if (!von) return 0;
        return colors[h / 80];
    endfunction

    initial begin
        int hs_low, ls_cnt, von_cnt, exp_h;
        int vs_low, fs_cnt, last_fs, s_von_cnt, first_vs_h, first_vs_v;
        int prev_h, prev_v;

        //         n    rst   pen   h    v    hs    vs    von   ls    fs
        tv[0] = '{3,   1'b1, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1,   1'b0, 1'b1, 0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tv[2] = '{1,   1'b0, 1'b1, 1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[3] = '{638, 1'b0, 1'b1, 639, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1,   1'b0, 1'b1, 640, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[5] = '{16,  1'b0, 1'b1, 656, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[6] = '{95,  1'b0, 1'b1, 751, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[7] = '{1,   1'b0, 1'b1, 752, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[8] = '{47,  1'b0, 1'b1, 799, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[9] = '{1,   1'b0, 1'b1, 0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1; pix_en = 1'b1;
        s_reset = 1'b1; s_pix_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            reset  = tv[i].rst;
            pix_en = tv[i].pen;
            for (int c = 0; c < tv[i].n; c++) step();
            chk_all($sformatf("vec%0d", i), tv[i].h, tv[i].v,
                    tv[i].hs, tv[i].vs, tv[i].von, tv[i].ls, tv[i].fs);
        end

        // One full line starting from (0,1): sync width, visible width, one strobe.
        hs_low = 0; ls_cnt = 0; von_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            step();
            if (!hsync_n) hs_low++;
            if (line_start) ls_cnt++;
            if (video_on) von_cnt++;
        end
        chk("line_hsync_low_cycles", hs_low, 96);
        chk("line_start_count", ls_cnt, 1);
        chk("line_video_on_cycles", von_cnt, 640);
        chk_all("line_end", 0, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Mid-frame reset with pix_en low still loads the idle state.
        for (int c = 0; c < 300; c++) step();
        chk_all("pre_rst", 300, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1; pix_en = 1'b0;
        step();
        chk_all("midrst", 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; pix_en = 1'b1;
        step();
        chk_all("after_rst", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // A stall right after a strobe must drop the strobe but hold the rest.
        pix_en = 1'b0;
        step();
        chk_all("stall_strobe", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Move to (637,0) then alternate pix_en.
        pix_en = 1'b1;
        for (int c = 0; c < 637; c++) step();
        chk_all("at637", 637, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_h = 637;
        for (int i = 0; i < 8; i++) begin
            pix_en = (i % 2 == 0);
            step();
            if (i % 2 == 0) exp_h++;
            chk($sformatf("tog%0d_hcount", i), int'(hcount), exp_h);
            chk($sformatf("tog%0d_video_on", i), int'(video_on), int'(exp_h < 640));
            chk($sformatf("tog%0d_line_start", i), int'(line_start), 0);
        end

        // Small-timing instance: two whole frames.
        pix_en = 1'b1;
        step(); step();
        s_reset = 1'b0;
        vs_low = 0; fs_cnt = 0; last_fs = -1; s_von_cnt = 0;
        first_vs_h = -1; first_vs_v = -1;
        prev_h = int'(s_hcount); prev_v = int'(s_vcount);
        chk("s_reset_hcount", prev_h, 15);
        chk("s_reset_vcount", prev_v, 7);
        for (int c = 1; c <= 257; c++) begin
            step();
            if (!s_vsync_n) begin
                if (c <= 256) vs_low++;
                if (first_vs_h < 0) begin
                    first_vs_h = int'(s_hcount);
                    first_vs_v = int'(s_vcount);
                end
            end
            if (s_video_on) s_von_cnt++;
            if (s_frame_start) begin
                fs_cnt++;
                chk($sformatf("s_fs%0d_pos", fs_cnt), int'(s_hcount) + 100 * int'(s_vcount), 0);
                chk($sformatf("s_fs%0d_prev", fs_cnt), prev_h + 100 * prev_v, 715);
                if (last_fs >= 0) chk("s_frame_period", c - last_fs, 128);
                last_fs = c;
            end
            prev_h = int'(s_hcount); prev_v = int'(s_vcount);
        end
        chk("s_frame_start_count", fs_cnt, 3);
        chk("s_vsync_low_cycles", vs_low, 64);
        chk("s_vsync_first_h", first_vs_h, 0);
        chk("s_vsync_first_v", first_vs_v, 5);
        chk("s_video_on_cycles", s_von_cnt, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
